// File: rtl/mac_out_scheduler_if.sv
// Bundle of the lane, FIFO and downstream signals of mac_out_scheduler.
// stall_cnt is present only when ARB_STALL_CNT_EN is defined.
interface mac_out_scheduler_if #(
  parameter int DataWidth   = 32,
  parameter int BufferWidth = 2,
  parameter int NUM_REQ     = 4
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*DataWidth-1:0] req_data;
  logic [NUM_REQ-1:0]           gnt;
  logic                         flush;
  logic                         fifo_push;
  logic [DataWidth-1:0]         fifo_din;
  logic                         fifo_full;
  logic                         fifo_pop;
  logic [DataWidth-1:0]         fifo_dout;
  logic                         out_valid;
  logic                         out_ready;
  logic [DataWidth-1:0]         out_data;
  logic                         out_last;
  logic [BufferWidth:0]         count;
  logic                         busy;
`ifdef ARB_STALL_CNT_EN
  logic [15:0]                  stall_cnt;

  modport slave (
    input  req, req_data, flush, fifo_full, fifo_dout, out_ready,
    output gnt, fifo_push, fifo_din, fifo_pop, out_valid, out_data, out_last,
           count, busy, stall_cnt
  );
  modport master (
    output req, req_data, flush, fifo_full, fifo_dout, out_ready,
    input  gnt, fifo_push, fifo_din, fifo_pop, out_valid, out_data, out_last,
           count, busy, stall_cnt
  );
`else
  modport slave (
    input  req, req_data, flush, fifo_full, fifo_dout, out_ready,
    output gnt, fifo_push, fifo_din, fifo_pop, out_valid, out_data, out_last,
           count, busy
  );
  modport master (
    output req, req_data, flush, fifo_full, fifo_dout, out_ready,
    input  gnt, fifo_push, fifo_din, fifo_pop, out_valid, out_data, out_last,
           count, busy
  );
`endif
endinterface

// File: rtl/mac_out_scheduler.sv
// Round-robin lane-to-FIFO arbiter plus burst/flush drain FSM for the MAC output FIFO.
// Optional macro ARB_STALL_CNT_EN adds a saturating 16-bit stall counter.
module mac_out_scheduler #(
  parameter int DataWidth   = 32,
  parameter int BufferWidth = 2,
  parameter int BufferSize  = 4,
  parameter int NUM_REQ     = 4,
  parameter int BURST_LEN   = 4
) (
  input  logic                clk,
  input  logic                aclr,
  mac_out_scheduler_if.slave  bus
);
  localparam int CntW = BufferWidth + 1;
  localparam int PtrW = $clog2(NUM_REQ);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  localparam logic [CntW-1:0] FULL_CNT  = CntW'(BufferSize);
  localparam logic [CntW-1:0] BURST_CNT = CntW'(BURST_LEN);
  localparam logic [CntW-1:0] ONE_CNT   = CntW'(1);
  localparam logic [PtrW-1:0] LAST_LANE = PtrW'(NUM_REQ - 1);

  logic [CntW-1:0] count_q, count_d, beats_q, beats_d;
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d, winner;
  logic [0:0]      state_q, state_d;
  logic            is_flush_q, is_flush_d, flush_pend_q, flush_pend_d;
  logic            can_push, found, push, pop, in_drain, last_beat;
  int              idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = PtrW'(idx);
      end
    end
  end

  // Pushes are suppressed while aclr is high so no grant is seen during reset.
  assign can_push      = (count_q < FULL_CNT) & ~bus.fifo_full;
  assign push          = can_push & found & ~aclr;
  assign bus.gnt       = push ? (NUM_REQ'(1) << winner) : '0;
  assign bus.fifo_push = push;
  assign bus.fifo_din  = bus.req_data[int'(winner)*DataWidth +: DataWidth];

  assign in_drain      = (state_q == DRAIN);
  assign last_beat     = in_drain & (beats_q == ONE_CNT);
  assign pop           = in_drain & bus.out_ready;
  assign bus.fifo_pop  = pop;
  assign bus.out_valid = in_drain;
  assign bus.out_last  = last_beat;
  assign bus.out_data  = bus.fifo_dout;
  assign bus.count     = count_q;
  assign bus.busy      = in_drain | flush_pend_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push) rr_ptr_d = (winner == LAST_LANE) ? '0 : winner + 1'b1;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    state_d    = state_q;
    beats_d    = beats_q;
    is_flush_d = is_flush_q;
    case (state_q)
      IDLE: begin
        if (count_q >= BURST_CNT) begin
          state_d    = DRAIN;
          beats_d    = BURST_CNT;
          is_flush_d = 1'b0;
        end else if (flush_pend_q && count_q != '0) begin
          state_d    = DRAIN;
          beats_d    = count_q;
          is_flush_d = 1'b1;
        end
      end
      default: begin
        if (pop) begin
          beats_d = beats_q - 1'b1;
          if (last_beat) state_d = IDLE;
        end
      end
    endcase

    // A new flush pulse wins over a same-cycle clear.
    flush_pend_d = flush_pend_q;
    if ((pop && last_beat && is_flush_q) || (state_q == IDLE && count_q == '0))
      flush_pend_d = 1'b0;
    if (bus.flush) flush_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      count_q      <= '0;
      beats_q      <= '0;
      rr_ptr_q     <= '0;
      state_q      <= IDLE;
      is_flush_q   <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      beats_q      <= beats_d;
      rr_ptr_q     <= rr_ptr_d;
      state_q      <= state_d;
      is_flush_q   <= is_flush_d;
      flush_pend_q <= flush_pend_d;
    end
  end

`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|bus.req) && !can_push && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (aclr) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_mac_out_scheduler.sv
// Directed bench for mac_out_scheduler with a small behavioural FIFO on the push/pop side.
module tb_mac_out_scheduler;
  logic clk = 1'b0;
  logic aclr;
  always #5 clk = ~clk;

  mac_out_scheduler_if #(.DataWidth(32), .BufferWidth(2), .NUM_REQ(4)) bus ();

  mac_out_scheduler #(
    .DataWidth(32), .BufferWidth(2), .BufferSize(4), .NUM_REQ(4), .BURST_LEN(4)
  ) dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus)
  );

  logic [31:0] ld [4];
  always_comb bus.req_data = {ld[3], ld[2], ld[1], ld[0]};

  // Behavioural 4-deep FIFO with a combinational head word.
  logic [31:0] fmem [4];
  logic [1:0]  fwr, frd;
  logic [2:0]  fcnt;
  logic        ovf, unf;
  assign bus.fifo_full = (fcnt == 3'd4);
  assign bus.fifo_dout = fmem[frd];

  always @(posedge clk) begin
    if (aclr) begin
      fwr <= '0; frd <= '0; fcnt <= '0;
    end else begin
      if (bus.fifo_push && fcnt == 3'd4) ovf <= 1'b1;
      if (bus.fifo_pop && fcnt == 3'd0)  unf <= 1'b1;
      if (bus.fifo_push) begin fmem[fwr] <= bus.fifo_din; fwr <= fwr + 2'd1; end
      if (bus.fifo_pop) frd <= frd + 2'd1;
      fcnt <= fcnt + {2'b0, bus.fifo_push} - {2'b0, bus.fifo_pop};
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    aclr = 1'b1; bus.req = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    tick(); tick();
    aclr = 1'b0;
  endtask

  logic [31:0] cap_d [16];
  logic        cap_l [16];
  int          cap_n;

  task automatic collect(input int n, input int budget);
    cap_n = 0;
    for (int c = 0; c < budget && cap_n < n; c++) begin
      samp();
      if (bus.out_valid && bus.out_ready) begin
        cap_d[cap_n] = bus.out_data;
        cap_l[cap_n] = bus.out_last;
        cap_n++;
      end
      tick();
    end
    chk("burst_beats", cap_n, n);
  endtask

  int g_seq [8];
  int g_n, b_n;

  initial begin
    ovf = 1'b0; unf = 1'b0;
    ld[0] = 32'hA000_0000; ld[1] = 32'hA000_0001;
    ld[2] = 32'hA000_0002; ld[3] = 32'hA000_0003;

    // Reset state
    do_reset();
    samp();
    chk("rst_count", bus.count, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_push", bus.fifo_push, 0);
    chk("rst_pop", bus.fifo_pop, 0);
    chk("rst_busy", bus.busy, 0);
`ifdef ARB_STALL_CNT_EN
    chk("rst_stall", bus.stall_cnt, 0);
`endif
    tick();

    // Round-robin with all lanes requesting
    do_reset();
    bus.req = 4'b1111; bus.out_ready = 1'b1;
    g_n = 0; b_n = 0;
    for (int c = 0; c < 24; c++) begin
      samp();
      if (c == 4) begin
        chk("rr_full_count", bus.count, 4);
        chk("rr_full_gnt", bus.gnt, 0);
      end
      if (c == 5) chk("rr_first_valid", bus.out_valid, 1);
      if (bus.gnt != 0 && g_n < 8) begin
        chk("rr_onehot", $countones(bus.gnt), 1);
        for (int i = 0; i < 4; i++) if (bus.gnt[i]) g_seq[g_n] = i;
        g_n++;
      end
      if (bus.out_valid && bus.out_ready && b_n < 8) begin
        cap_d[b_n] = bus.out_data; cap_l[b_n] = bus.out_last; b_n++;
      end
      tick();
    end
    chk("rr_gnt_cnt", g_n, 8);
    chk("rr_beat_cnt", b_n, 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rr_gnt_%0d", k), g_seq[k], k % 4);
      chk($sformatf("rr_data_%0d", k), cap_d[k], 32'hA000_0000 + (k % 4));
      chk($sformatf("rr_last_%0d", k), cap_l[k], (k % 4) == 3);
    end

    // Full backpressure
    do_reset();
    bus.req = 4'b0101; bus.out_ready = 1'b0;
    samp(); chk("bp_gnt0", bus.gnt, 4'b0001); tick();
    samp(); chk("bp_gnt1", bus.gnt, 4'b0100); tick();
    samp(); chk("bp_gnt2", bus.gnt, 4'b0001); tick();
    samp(); chk("bp_gnt3", bus.gnt, 4'b0100); tick();
    samp();
    chk("bp_count", bus.count, 4);
    chk("bp_gnt_full", bus.gnt, 0);
    chk("bp_push_full", bus.fifo_push, 0);
    tick();
    samp();
    chk("bp_valid", bus.out_valid, 1);
    chk("bp_data", bus.out_data, 32'hA000_0000);
    chk("bp_pop_hold", bus.fifo_pop, 0);
`ifdef ARB_STALL_CNT_EN
    chk("bp_stall1", bus.stall_cnt, 1);
`endif
    tick();
    samp();
    chk("bp_valid_hold", bus.out_valid, 1);
    chk("bp_data_hold", bus.out_data, 32'hA000_0000);
    chk("bp_count_hold", bus.count, 4);
`ifdef ARB_STALL_CNT_EN
    chk("bp_stall2", bus.stall_cnt, 2);
`endif
    tick();
    bus.req = '0; bus.out_ready = 1'b1;
    collect(4, 10);
    chk("bp_d0", cap_d[0], 32'hA000_0000);
    chk("bp_d1", cap_d[1], 32'hA000_0002);
    chk("bp_d2", cap_d[2], 32'hA000_0000);
    chk("bp_d3", cap_d[3], 32'hA000_0002);
    chk("bp_l2", cap_l[2], 0);
    chk("bp_l3", cap_l[3], 1);

    // Flush residual of three words
    do_reset();
    bus.out_ready = 1'b1; bus.req = 4'b0010;
    ld[1] = 32'h0000_00AA; samp(); chk("fl_gnt_a", bus.gnt, 4'b0010); tick();
    ld[1] = 32'h0000_00BB; tick();
    ld[1] = 32'h0000_00CC; tick();
    bus.req = '0; bus.flush = 1'b1;
    samp(); chk("fl_busy_pre", bus.busy, 0); tick();
    bus.flush = 1'b0;
    samp(); chk("fl_busy_pend", bus.busy, 1); chk("fl_count", bus.count, 3); tick();
    collect(3, 8);
    chk("fl_d0", cap_d[0], 32'h0000_00AA);
    chk("fl_d1", cap_d[1], 32'h0000_00BB);
    chk("fl_d2", cap_d[2], 32'h0000_00CC);
    chk("fl_l1", cap_l[1], 0);
    chk("fl_l2", cap_l[2], 1);
    samp();
    chk("fl_count_end", bus.count, 0);
    chk("fl_busy_end", bus.busy, 0);
    tick();

    // Flush arriving during a normal burst
    do_reset();
    bus.req = 4'b0100;
    for (int k = 0; k < 4; k++) begin ld[2] = 32'hB000_0000 + k; tick(); end
    bus.req = '0; bus.out_ready = 1'b1;
    samp(); chk("fd_count4", bus.count, 4); chk("fd_idle", bus.out_valid, 0); tick();
    samp(); chk("fd_w0", bus.out_data, 32'hB000_0000); tick();
    bus.flush = 1'b1; bus.req = 4'b1000; ld[3] = 32'hC000_0000;
    samp(); chk("fd_w1", bus.out_data, 32'hB000_0001); chk("fd_gnt_x0", bus.gnt, 4'b1000); tick();
    bus.flush = 1'b0; ld[3] = 32'hC000_0001;
    samp(); chk("fd_w2", bus.out_data, 32'hB000_0002); chk("fd_count3", bus.count, 3); tick();
    bus.req = '0;
    samp(); chk("fd_w3", bus.out_data, 32'hB000_0003); chk("fd_w3_last", bus.out_last, 1); tick();
    samp(); chk("fd_gap", bus.out_valid, 0); chk("fd_gap_busy", bus.busy, 1);
    chk("fd_gap_count", bus.count, 2); tick();
    samp(); chk("fd_x0", bus.out_data, 32'hC000_0000); chk("fd_x0_last", bus.out_last, 0); tick();
    samp(); chk("fd_x1", bus.out_data, 32'hC000_0001); chk("fd_x1_last", bus.out_last, 1); tick();
    samp(); chk("fd_end_valid", bus.out_valid, 0); chk("fd_end_busy", bus.busy, 0);
    chk("fd_end_count", bus.count, 0); tick();

    // Concurrent push and pop at count 2
    do_reset();
    bus.out_ready = 1'b1; bus.req = 4'b0010;
    ld[1] = 32'hD000_0000; tick();
    ld[1] = 32'hD000_0001; tick();
    bus.req = '0; bus.flush = 1'b1; tick();
    bus.flush = 1'b0;
    samp(); chk("sim_count_a", bus.count, 2); tick();
    bus.req = 4'b0010; ld[1] = 32'hD000_0002;
    samp(); chk("sim_d0", bus.out_data, 32'hD000_0000); chk("sim_gnt_a", bus.gnt, 4'b0010);
    chk("sim_count_b", bus.count, 2); tick();
    ld[1] = 32'hD000_0003;
    samp(); chk("sim_d1", bus.out_data, 32'hD000_0001); chk("sim_last", bus.out_last, 1);
    chk("sim_count_c", bus.count, 2); tick();
    bus.req = '0; bus.flush = 1'b1;
    samp(); chk("sim_count_d", bus.count, 2); chk("sim_idle", bus.out_valid, 0); tick();
    bus.flush = 1'b0;
    collect(2, 8);
    chk("sim_d2", cap_d[0], 32'hD000_0002);
    chk("sim_d3", cap_d[1], 32'hD000_0003);
    chk("sim_l3", cap_l[1], 1);

    // Reset in the middle of a burst
    do_reset();
    bus.req = 4'b0100;
    for (int k = 0; k < 4; k++) begin ld[2] = 32'hE000_0000 + k; tick(); end
    bus.req = '0; bus.out_ready = 1'b1; tick();
    samp(); chk("mr_beat1", bus.out_valid, 1); tick();
    aclr = 1'b1; tick();
    aclr = 1'b0;
    samp();
    chk("mr_count", bus.count, 0);
    chk("mr_valid", bus.out_valid, 0);
    chk("mr_gnt", bus.gnt, 0);
    chk("mr_busy", bus.busy, 0);
    tick();
    bus.req = 4'b1111;
    samp(); chk("mr_rr_ptr", bus.gnt, 4'b0001); tick();
    bus.req = '0;

    chk("fifo_overflow", ovf, 0);
    chk("fifo_underflow", unf, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
